// File: rtl/stack_cmd_master_if.sv
// Command/response channel between a requester and stack_cmd_master.
// The requester drives commands and consumes responses through the master modport.
interface stack_cmd_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/stack_cmd_master.sv
// Push/pop command initiator for the 8-bit stack controller; one command in flight.
// Define STACK_CMD_MASTER_TIMEOUT_EN to abort a missing acknowledge after ACK_TIMEOUT cycles.
module stack_cmd_master #(
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    stack_cmd_master_if.slave  cmd_if,
    output logic [7:0]         st_din,
    output logic               st_push,
    output logic               st_pop,
    input  logic [7:0]         st_dout,
    input  logic               st_pushed,
    input  logic               st_poped,
    input  logic               st_full,
    input  logic               st_empty
);

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
            $error("stack_cmd_master: RD_LAT must be 1..4");
        end
        if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_ack_timeout
            $error("stack_cmd_master: ACK_TIMEOUT must be 1..255");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_OVF = 2'b01;
    localparam logic [1:0] ERR_UDF = 2'b10;
    localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);

    state_t     state_q, state_d;
    logic       op_q, op_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [1:0] rsp_err_q, rsp_err_d;
    logic [7:0] st_din_q, st_din_d;
    logic       st_push_q, st_push_d;
    logic       st_pop_q, st_pop_d;
    logic [2:0] rd_cnt_q, rd_cnt_d;
`ifdef STACK_CMD_MASTER_TIMEOUT_EN
    localparam logic [1:0] ERR_TO  = 2'b11;
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
    logic [7:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        st_din_d   = st_din_q;
        st_push_d  = 1'b0;
        st_pop_d   = 1'b0;
        rd_cnt_d   = rd_cnt_q;
`ifdef STACK_CMD_MASTER_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_if.cmd_valid && cmd_ready_q) begin
                    op_d     = cmd_if.cmd_op;
                    st_din_d = cmd_if.cmd_data;
                    // Flags are judged only here; later flag changes do not affect this command.
                    if (!cmd_if.cmd_op && st_full) begin
                        state_d    = RESP;
                        rsp_err_d  = ERR_OVF;
                        rsp_data_d = 8'h00;
                    end else if (cmd_if.cmd_op && st_empty) begin
                        state_d    = RESP;
                        rsp_err_d  = ERR_UDF;
                        rsp_data_d = 8'h00;
                    end else begin
                        state_d   = ISSUE;
                        st_push_d = !cmd_if.cmd_op;
                        st_pop_d  = cmd_if.cmd_op;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
`ifdef STACK_CMD_MASTER_TIMEOUT_EN
                to_cnt_d = 8'h00;
`endif
            end
            WAIT_ACK: begin
                if (!op_q && st_pushed) begin
                    state_d    = RESP;
                    rsp_err_d  = ERR_OK;
                    rsp_data_d = st_din_q;
                end else if (op_q && st_poped) begin
                    state_d  = RD_WAIT;
                    rd_cnt_d = 3'd0;
                end
`ifdef STACK_CMD_MASTER_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d    = RESP;
                    rsp_err_d  = ERR_TO;
                    rsp_data_d = 8'h00;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
`endif
            end
            RD_WAIT: begin
                if (rd_cnt_q == RD_LAST) begin
                    state_d    = RESP;
                    rsp_err_d  = ERR_OK;
                    rsp_data_d = st_dout;
                end else begin
                    rd_cnt_d = rd_cnt_q + 3'd1;
                end
            end
            RESP: begin
                if (cmd_if.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered images of the next state.
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 2'b00;
            st_din_q    <= 8'h00;
            st_push_q   <= 1'b0;
            st_pop_q    <= 1'b0;
            rd_cnt_q    <= 3'd0;
`ifdef STACK_CMD_MASTER_TIMEOUT_EN
            to_cnt_q    <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            st_din_q    <= st_din_d;
            st_push_q   <= st_push_d;
            st_pop_q    <= st_pop_d;
            rd_cnt_q    <= rd_cnt_d;
`ifdef STACK_CMD_MASTER_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign cmd_if.cmd_ready = cmd_ready_q;
    assign cmd_if.rsp_valid = rsp_valid_q;
    assign cmd_if.rsp_data  = rsp_data_q;
    assign cmd_if.rsp_err   = rsp_err_q;
    assign st_din           = st_din_q;
    assign st_push          = st_push_q;
    assign st_pop           = st_pop_q;

endmodule
